// File: rtl/l2_config_and_types_pkg.sv
// l2_config_and_types: shared L2 sub-id width, L1 arbiter request record and arbiter state encoding
package l2_config_and_types;
  localparam int L2_SUB_ID_W = 2;
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic        rnw;
    logic        is_amo;
    logic [4:0]  amo_type_or_burst_size;
    logic [31:0] wr_data;
  } l1_arb_request_t;
  typedef enum logic {ARB, AMO_LOCK} arb_state_t;
endpackage

// File: rtl/l1_request_arbiter_rr_grant.sv
// rr_grant: picks the first requester at or after ptr, wrapping around
module rr_grant #(
  parameter int N = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  // scan from ptr and stop at the first active request
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++)
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
        grant[(int'(ptr) + k) % N] = 1'b1;
      end
  end
endmodule

// File: rtl/l1_request_arbiter.sv
// l1_request_arbiter: shares one L2 request port among L1 clients; L1_ARB_FIXED_PRIORITY_EN selects fixed priority with starvation promotion
module l1_request_arbiter
  import l2_config_and_types::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int MAX_OUTSTANDING_READS = 8,
  parameter int ID_W = L2_SUB_ID_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQUESTERS-1:0]    req_valid,
  output logic [NUM_REQUESTERS-1:0]    req_ready,
  input  logic [NUM_REQUESTERS*30-1:0] req_addr,
  input  logic [NUM_REQUESTERS*4-1:0]  req_be,
  input  logic [NUM_REQUESTERS-1:0]    req_rnw,
  input  logic [NUM_REQUESTERS-1:0]    req_is_amo,
  input  logic [NUM_REQUESTERS*5-1:0]  req_amo_type_or_burst_size,
  input  logic [NUM_REQUESTERS*32-1:0] req_wr_data,
  output logic [NUM_REQUESTERS-1:0]    rd_valid,
  output logic [31:0]                  rd_data,
  output logic                         l2_request_push,
  output logic [29:0]                  l2_addr,
  output logic [3:0]                   l2_be,
  output logic                         l2_rnw,
  output logic                         l2_is_amo,
  output logic [4:0]                   l2_amo_type_or_burst_size,
  output logic [ID_W-1:0]              l2_sub_id,
  output logic                         l2_wr_data_push,
  output logic [31:0]                  l2_wr_data,
  input  logic                         l2_request_full,
  input  logic                         l2_data_full,
  input  logic [31:0]                  l2_rd_data,
  input  logic                         l2_rd_data_valid,
  input  logic [ID_W-1:0]              l2_rd_sub_id
);
  localparam int N = NUM_REQUESTERS;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_OUTSTANDING_READS) + 1;
  l1_arb_request_t req [N];
  logic [CW-1:0] rd_count [N];
  logic [CW-1:0] next_count [N];
  logic [31:0] sum [N];
  logic [N-1:0] elig, arb_req, grant, ret_hit;
  logic [PW-1:0] ptr, gidx, owner;
  logic any;
  arb_state_t state;
  // unpack client fields and decide who may compete this cycle; AMOs count as reads since they return data
  always_comb
    for (int i = 0; i < N; i++) begin
      req[i].addr = req_addr[i*30 +: 30];
      req[i].be = req_be[i*4 +: 4];
      req[i].rnw = req_rnw[i];
      req[i].is_amo = req_is_amo[i];
      req[i].amo_type_or_burst_size = req_amo_type_or_burst_size[i*5 +: 5];
      req[i].wr_data = req_wr_data[i*32 +: 32];
      elig[i] = req_valid[i] & ~l2_request_full & (req_rnw[i] | ~l2_data_full)
              & (~(req_rnw[i] | req_is_amo[i])
                 | (32'(rd_count[i]) + 32'(req[i].amo_type_or_burst_size) + 32'd1 <= 32'(MAX_OUTSTANDING_READS)))
              & (state == ARB || PW'(i) == owner);
    end
  rr_grant #(.N(N), .PW(PW)) u_grant (
    .req(arb_req),
    .ptr(ptr),
    .grant(grant),
    .idx(gidx),
    .any(any)
  );
`ifdef L1_ARB_FIXED_PRIORITY_EN
  logic [3:0] starve [N];
  logic [N-1:0] promo;
  assign ptr = '0;
  // starved eligible clients jump ahead of the fixed index order
  always_comb begin
    for (int i = 0; i < N; i++) promo[i] = elig[i] & (starve[i] == 4'd15);
    arb_req = |promo ? promo : elig;
  end
  // count cycles each client waits while valid; a grant clears the wait
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      starve[i] <= (rst || grant[i]) ? 4'd0 : (req_valid[i] && starve[i] != 4'd15) ? starve[i] + 4'd1 : starve[i];
`else
  logic [PW-1:0] rr_ptr;
  assign ptr = rr_ptr;
  assign arb_req = elig;
  // pointer moves just past the last winner
  always_ff @(posedge clk)
    if (rst) rr_ptr <= '0;
    else if (any) rr_ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
`endif
  // net outstanding-read count per client; a return with nothing outstanding saturates at 0
  always_comb
    for (int i = 0; i < N; i++) begin
      ret_hit[i] = l2_rd_data_valid & (32'(l2_rd_sub_id) == i);
      sum[i] = 32'(rd_count[i]) + ((grant[i] & (req[i].rnw | req[i].is_amo)) ? 32'(req[i].amo_type_or_burst_size) + 32'd1 : 32'd0);
      next_count[i] = (sum[i] == 32'd0) ? '0 : CW'(sum[i] - 32'(ret_hit[i]));
    end
  // outstanding-read counters
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++) rd_count[i] <= rst ? '0 : next_count[i];
  // AMO lock: only the owner competes until its reads have all returned
  always_ff @(posedge clk)
    if (rst) begin
      state <= ARB;
      owner <= '0;
    end else if (state == ARB) begin
      if (any && req[gidx].is_amo) begin
        state <= AMO_LOCK;
        owner <= gidx;
      end
    end else if (ret_hit[owner] && next_count[owner] == '0) state <= ARB;
  // registered read return, routed by sub_id
  always_ff @(posedge clk)
    if (rst) begin
      rd_valid <= '0;
      rd_data <= '0;
    end else begin
      rd_valid <= ret_hit;
      rd_data <= l2_rd_data;
    end
  // protocol checks on client requests and L2 returns
  always_ff @(posedge clk)
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        assert (!(ret_hit[i] && sum[i] == 32'd0));
        assert (!(req_valid[i] && req_rnw[i] && !req_is_amo[i]
                  && 32'(req[i].amo_type_or_burst_size) >= 32'(MAX_OUTSTANDING_READS)));
      end
      assert (!(l2_rd_data_valid && 32'(l2_rd_sub_id) >= 32'(N)));
    end
  assign req_ready = rst ? '0 : grant;
  assign l2_request_push = |req_ready;
  assign l2_wr_data_push = l2_request_push & ~req[gidx].rnw;
  assign l2_addr = req[gidx].addr;
  assign l2_be = req[gidx].be;
  assign l2_rnw = req[gidx].rnw;
  assign l2_is_amo = req[gidx].is_amo;
  assign l2_amo_type_or_burst_size = req[gidx].amo_type_or_burst_size;
  assign l2_wr_data = req[gidx].wr_data;
  assign l2_sub_id = ID_W'(gidx);
endmodule

// File: tb/tb_l1_request_arbiter.sv
// tb_l1_request_arbiter: directed checks of grant order, write pairing, read cap, AMO lock, returns and reset
module tb_l1_request_arbiter;
  import l2_config_and_types::*;
  localparam int N = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [N-1:0] req_valid, req_ready, req_rnw, req_is_amo, rd_valid;
  logic [N*30-1:0] req_addr;
  logic [N*4-1:0] req_be;
  logic [N*5-1:0] req_amo_type_or_burst_size;
  logic [N*32-1:0] req_wr_data;
  logic [31:0] rd_data, l2_wr_data, l2_rd_data;
  logic l2_request_push, l2_rnw, l2_is_amo, l2_wr_data_push;
  logic l2_request_full, l2_data_full, l2_rd_data_valid;
  logic [29:0] l2_addr;
  logic [3:0] l2_be;
  logic [4:0] l2_amo_type_or_burst_size;
  logic [1:0] l2_sub_id, l2_rd_sub_id;
  int total = 0;
  int bad = 0;

  l1_request_arbiter #(.NUM_REQUESTERS(N), .MAX_OUTSTANDING_READS(8), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_be(req_be),
    .req_rnw(req_rnw), .req_is_amo(req_is_amo),
    .req_amo_type_or_burst_size(req_amo_type_or_burst_size), .req_wr_data(req_wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .l2_request_push(l2_request_push), .l2_addr(l2_addr), .l2_be(l2_be), .l2_rnw(l2_rnw),
    .l2_is_amo(l2_is_amo), .l2_amo_type_or_burst_size(l2_amo_type_or_burst_size),
    .l2_sub_id(l2_sub_id), .l2_wr_data_push(l2_wr_data_push), .l2_wr_data(l2_wr_data),
    .l2_request_full(l2_request_full), .l2_data_full(l2_data_full),
    .l2_rd_data(l2_rd_data), .l2_rd_data_valid(l2_rd_data_valid), .l2_rd_sub_id(l2_rd_sub_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input int i, input logic v, input logic rnw, input logic amo,
                     input logic [4:0] b, input logic [29:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_rnw[i] = rnw;
    req_is_amo[i] = amo;
    req_amo_type_or_burst_size[i*5 +: 5] = b;
    req_addr[i*30 +: 30] = a;
    req_wr_data[i*32 +: 32] = d;
    req_be[i*4 +: 4] = 4'hF;
  endtask

  task automatic ret(input logic [1:0] s, input logic [31:0] d);
    l2_rd_data_valid = 1'b1;
    l2_rd_sub_id = s;
    l2_rd_data = d;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_rnw = '0; req_is_amo = '0; req_addr = '0; req_be = '0;
    req_amo_type_or_burst_size = '0; req_wr_data = '0;
    l2_request_full = 1'b0; l2_data_full = 1'b0;
    l2_rd_data = '0; l2_rd_data_valid = 1'b0; l2_rd_sub_id = '0;
    cyc(); cyc();
    // reset forces grants off even with requests pending
    set(0, 1, 1, 0, 0, 30'h10, 0);
    set(1, 1, 1, 0, 0, 30'h20, 0);
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_push", l2_request_push, 0);
    chk("rst_rd_valid", rd_valid, 2'b00);
    chk("rst_rd_data", rd_data, 0);
    // continuous single reads alternate 0,1,0,1
    cyc(); rst = 1'b0; #1;
    chk("rr_g0", req_ready, 2'b01);
    chk("rr_sub0", l2_sub_id, 0);
    chk("rr_addr0", l2_addr, 30'h10);
    chk("rr_rd_no_wdp", l2_wr_data_push, 0);
    cyc(); #1;
    chk("rr_g1", req_ready, 2'b10);
    chk("rr_sub1", l2_sub_id, 1);
    chk("rr_addr1", l2_addr, 30'h20);
    chk("rr_push", l2_request_push, 1);
    cyc(); #1;
    chk("rr_g2", req_ready, 2'b01);
    cyc(); #1;
    chk("rr_g3", req_ready, 2'b10);
    // returns route by sub_id with one cycle latency
    cyc(); req_valid = '0; ret(1, 32'h12345678); #1;
    chk("ret_pre", rd_valid, 2'b00);
    cyc(); ret(1, 32'h0BADF00D); #1;
    chk("ret_valid1", rd_valid, 2'b10);
    chk("ret_data1", rd_data, 32'h12345678);
    cyc(); ret(0, 32'h1);
    cyc(); ret(0, 32'h2);
    cyc(); l2_rd_data_valid = 1'b0; #1;
    chk("ret_valid0", rd_valid, 2'b01);
    chk("ret_data0", rd_data, 32'h2);
    chk("ret_cnt0", dut.rd_count[0], 0);
    chk("ret_cnt1", dut.rd_count[1], 0);
    // write waits on data FIFO full while the read goes through
    l2_data_full = 1'b1;
    set(0, 1, 1, 0, 0, 30'h30, 0);
    set(1, 1, 0, 0, 0, 30'h100, 32'hDEADBEEF);
    #1;
    chk("wr_rd_g", req_ready, 2'b01);
    cyc(); req_valid[0] = 1'b0; #1;
    chk("wr_blocked", req_ready, 2'b00);
    chk("wr_blocked_push", l2_request_push, 0);
    cyc(); l2_data_full = 1'b0; #1;
    chk("wr_g", req_ready, 2'b10);
    chk("wr_wdp", l2_wr_data_push, 1);
    chk("wr_data", l2_wr_data, 32'hDEADBEEF);
    chk("wr_addr", l2_addr, 30'h100);
    chk("wr_rnw", l2_rnw, 0);
    chk("wr_be", l2_be, 4'hF);
    cyc(); req_valid = '0; ret(0, 32'h3);
    cyc(); l2_rd_data_valid = 1'b0;
    // read cap: two burst-4 reads fill it, a single read waits for a return
    set(0, 1, 1, 0, 3, 30'h40, 0); #1;
    chk("cap_g1", req_ready, 2'b01);
    chk("cap_burst", l2_amo_type_or_burst_size, 3);
    cyc(); #1;
    chk("cap_cnt4", dut.rd_count[0], 4);
    chk("cap_g2", req_ready, 2'b01);
    cyc(); set(0, 1, 1, 0, 0, 30'h44, 0); #1;
    chk("cap_cnt8", dut.rd_count[0], 8);
    chk("cap_blk", req_ready, 2'b00);
    cyc(); #1;
    chk("cap_blk2", req_ready, 2'b00);
    ret(0, 32'h77); #1;
    chk("cap_blk_ret", req_ready, 2'b00);
    cyc(); l2_rd_data_valid = 1'b0; #1;
    chk("cap_cnt7", dut.rd_count[0], 7);
    chk("cap_g3", req_ready, 2'b01);
    chk("cap_addr3", l2_addr, 30'h44);
    cyc(); req_valid = '0; #1;
    chk("cap_cnt8b", dut.rd_count[0], 8);
    for (int k = 0; k < 8; k++) begin
      ret(0, 32'(k));
      cyc();
    end
    l2_rd_data_valid = 1'b0; #1;
    chk("cap_drained", dut.rd_count[0], 0);
    // AMO from client 1 locks client 0 out until its return
    set(0, 1, 1, 0, 0, 30'h50, 0);
    set(1, 1, 0, 1, 0, 30'h60, 32'h5);
    #1;
    chk("amo_g", req_ready, 2'b10);
    chk("amo_wdp", l2_wr_data_push, 1);
    chk("amo_flag", l2_is_amo, 1);
    cyc(); req_valid[1] = 1'b0; #1;
    chk("amo_state", dut.state, AMO_LOCK);
    chk("amo_lock_blk", req_ready, 2'b00);
    cyc(); #1;
    chk("amo_lock_blk2", req_ready, 2'b00);
    ret(1, 32'hCAFEF00D); #1;
    chk("amo_lock_blk3", req_ready, 2'b00);
    cyc(); l2_rd_data_valid = 1'b0; #1;
    chk("amo_rd_valid", rd_valid, 2'b10);
    chk("amo_rd_data", rd_data, 32'hCAFEF00D);
    chk("amo_unlock_g", req_ready, 2'b01);
    cyc(); req_valid = '0; ret(0, 32'h9);
    cyc(); l2_rd_data_valid = 1'b0;
    // reset mid-lock with five outstanding clears state, counters and pointer
    set(0, 1, 0, 1, 4, 30'h70, 32'h1); #1;
    chk("rst5_g", req_ready, 2'b01);
    cyc(); req_valid = '0; #1;
    chk("rst5_cnt", dut.rd_count[0], 5);
    chk("rst5_lock", dut.state, AMO_LOCK);
    rst = 1'b1;
    set(0, 1, 1, 0, 0, 30'h80, 0);
    set(1, 1, 1, 0, 0, 30'h90, 0);
    ret(0, 32'hFFFF);
    #1;
    chk("rst5_ready", req_ready, 2'b00);
    chk("rst5_push", l2_request_push, 0);
    chk("rst5_wdp", l2_wr_data_push, 0);
    cyc(); rst = 1'b0; l2_rd_data_valid = 1'b0; #1;
    chk("rst5_state", dut.state, ARB);
    chk("rst5_cnt0", dut.rd_count[0], 0);
    chk("rst5_rd_valid", rd_valid, 2'b00);
    chk("rst5_rd_data", rd_data, 0);
    chk("rst5_ptr_g", req_ready, 2'b01);
    cyc(); req_valid = '0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
